// File: rtl/systolic_array_sequencer_if.sv
// Stream and array-side signal bundle between the layer buffer, the systolic array and its sequencer.
// The sequencer uses the slave view; the surrounding environment uses the master view.
interface systolic_array_sequencer_if #(
    parameter int DATA_SIZE = 16,
    parameter int SIZE      = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_SIZE*SIZE-1:0] in_data;
    logic [DATA_SIZE*SIZE-1:0] arr_z_to_z;
    logic [31:0]               arr_current_layer;
    logic [SIZE-1:0]           arr_one_address;
    logic                      arr_reset_counter;
    logic [31:0]               arr_address;
    logic [SIZE-1:0]           arr_output_replace_pattern;
    logic [DATA_SIZE*SIZE-1:0] arr_acc_z_to_z;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_SIZE*SIZE-1:0] out_data;
    logic [31:0]               out_layer;

    modport master (
        output in_valid, in_data, arr_acc_z_to_z, out_ready,
        input  in_ready, arr_z_to_z, arr_current_layer, arr_one_address, arr_reset_counter,
               arr_address, arr_output_replace_pattern, out_valid, out_data, out_layer
    );

    modport slave (
        input  in_valid, in_data, arr_acc_z_to_z, out_ready,
        output in_ready, arr_z_to_z, arr_current_layer, arr_one_address, arr_reset_counter,
               arr_address, arr_output_replace_pattern, out_valid, out_data, out_layer
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Drives one backprop pass through the systolic array: per-layer beat loading with a drain gap,
// then an address sweep that returns the accumulated results over a valid/ready stream.
module systolic_array_sequencer #(
    parameter int MAX_LAYER_SIZE = 5,
    parameter int DATA_SIZE      = 16,
    parameter int SIZE           = 3,
    parameter int DRAIN_CYCLES   = 2*SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [31:0]              i_cfg_layers,
    input  logic [SIZE-1:0]          i_cfg_replace_pattern,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    systolic_array_sequencer_if.slave bus
);
    localparam int BEAT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(SIZE - 1);
    localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [SIZE-1:0]   MSB_ONE    = SIZE'(1) << (SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_READ} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_cfg_layers;
    logic [SIZE-1:0]           r_cfg_pattern;
    logic [31:0]               r_layer;
    logic [BEAT_W-1:0]         r_beat;
    logic [DRN_W-1:0]          r_drain;
    logic                      r_first;
    logic [31:0]               r_rd;
    logic                      r_last_taken;
    logic                      r_out_valid;
    logic [DATA_SIZE*SIZE-1:0] r_out_data;
    logic [31:0]               r_out_layer;
    logic                      r_done;
    logic                      r_error;

    logic w_legal, w_accept, w_beat_last, w_drain_end, w_layer_last, w_rd_last, w_take, w_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_legal      = (i_cfg_layers != 32'd0) && (i_cfg_layers <= 32'(MAX_LAYER_SIZE));
        w_accept     = (r_state == S_LOAD) && bus.in_valid;
        w_beat_last  = (r_beat == LAST_BEAT);
        w_drain_end  = (r_state == S_DRAIN) && (r_drain == LAST_DRAIN);
        w_layer_last = (r_layer == r_cfg_layers - 32'd1);
        w_rd_last    = (r_rd == r_cfg_layers - 32'd1);
        // A new sample may enter the output register only when it is empty or draining this cycle.
        w_take       = (r_state == S_READ) && !r_last_taken && (!r_out_valid || bus.out_ready);
        w_finish     = (r_state == S_READ) && r_last_taken && r_out_valid && bus.out_ready;

        o_busy                         = (r_state != S_IDLE);
        bus.in_ready                   = (r_state == S_LOAD);
        bus.arr_z_to_z                 = w_accept ? bus.in_data : '0;
        bus.arr_one_address            = w_accept ? (MSB_ONE >> r_beat) : '0;
        bus.arr_reset_counter          = (r_state == S_LOAD) && r_first;
        bus.arr_current_layer          = ((r_state == S_LOAD) || (r_state == S_DRAIN)) ? r_layer : '0;
        bus.arr_address                = (r_state == S_READ) ? r_rd : '0;
        bus.arr_output_replace_pattern = (r_state == S_READ) ? r_cfg_pattern : '0;

        case (r_state)
            S_IDLE:  if (i_start && w_legal) w_next = S_LOAD;
            S_LOAD:  if (w_accept && w_beat_last) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = w_layer_last ? S_READ : S_LOAD;
            S_READ:  if (w_finish) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_layers  <= '0;
            r_cfg_pattern <= '0;
            r_layer       <= '0;
            r_beat        <= '0;
            r_drain       <= '0;
            r_first       <= 1'b0;
            r_rd          <= '0;
            r_last_taken  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_layer   <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_legal) begin
                            r_cfg_layers  <= i_cfg_layers;
                            r_cfg_pattern <= i_cfg_replace_pattern;
                            r_layer       <= '0;
                            r_beat        <= '0;
                            r_drain       <= '0;
                            r_first       <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_first <= 1'b0;
                    if (w_accept) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_drain <= '0;
                        if (w_layer_last) begin
                            r_rd         <= '0;
                            r_last_taken <= 1'b0;
                        end else begin
                            r_layer <= r_layer + 32'd1;
                            r_first <= 1'b1;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_READ: begin
                    if (w_take) begin
                        r_out_data  <= bus.arr_acc_z_to_z;
                        r_out_layer <= r_rd;
                        r_out_valid <= 1'b1;
                        // Address parks on the final layer so it never leaves the legal range.
                        if (w_rd_last) r_last_taken <= 1'b1;
                        else           r_rd         <= r_rd + 32'd1;
                    end else if (w_finish) begin
                        r_out_valid  <= 1'b0;
                        r_done       <= 1'b1;
                        r_rd         <= '0;
                        r_last_taken <= 1'b0;
                        r_layer      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_layer = r_out_layer;
    assign o_done        = r_done;
    assign o_error       = r_error;
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer: a transaction-level model checks every cycle,
// and each scenario pins a few hand-computed results.
module tb_systolic_array_sequencer;
    localparam int MAXL  = 5;
    localparam int DW    = 16;
    localparam int SIZE  = 3;
    localparam int DRAIN = 2*SIZE;
    localparam int W     = DW*SIZE;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     cfg_layers = '0;
    logic [SIZE-1:0] cfg_pat = '0;
    logic            busy, done, error;

    systolic_array_sequencer_if #(.DATA_SIZE(DW), .SIZE(SIZE)) sif ();

    systolic_array_sequencer #(
        .MAX_LAYER_SIZE(MAXL), .DATA_SIZE(DW), .SIZE(SIZE), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_start               (start),
        .i_cfg_layers          (cfg_layers),
        .i_cfg_replace_pattern (cfg_pat),
        .o_busy                (busy),
        .o_done                (done),
        .o_error               (error),
        .bus                   (sif)
    );

    always #5 clk = ~clk;

    // Array stand-in: accumulator contents are a fixed function of the address.
    function automatic logic [W-1:0] acc_fn(input logic [31:0] a);
        logic [15:0] x;
        x = a[15:0];
        return {16'h3000 + x*16'd7, 16'h2000 + x*16'd5, 16'h1000 + x*16'd3};
    endfunction
    assign sif.arr_acc_z_to_z = acc_fn(sif.arr_address);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit iv_tog    = 1'b0;
    bit stall_req = 1'b0;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        sif.in_valid = !iv_tog || cyc[0];
        sif.in_data  = {16'(cyc*3), 16'(cyc*5 + 1), 16'(cyc + 7)};
        if (stall_left > 0) begin
            sif.out_ready = 1'b0;
            stall_left--;
        end else if (stall_req && sif.out_valid) begin
            sif.out_ready = 1'b0;
            stall_left    = 3;
            stall_req     = 1'b0;
        end else begin
            sif.out_ready = 1'b1;
        end
    end

    // Model state: what the run must look like, derived from start, beat counts and handshakes.
    bit              m_busy, m_done, m_err, m_load, m_prev_load, m_in_read, m_prev_stall;
    int              m_L, m_beats, m_layer, m_gap, m_rd_idx;
    logic [SIZE-1:0] m_pat, e_oa;
    logic [W-1:0]    p_data;
    logic [31:0]     p_layer, p_addr;
    bit              hs_in, hs_out;

    int n_acc = 0, n_rc = 0, n_out = 0, n_err = 0, n_stall = 0;
    int oa_log[0:127];
    int lay_log[0:127];
    int out_log[0:127];
    logic [SIZE-1:0] cap_pat = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_zero", |{busy, done, error, sif.in_ready, sif.arr_z_to_z, sif.arr_current_layer,
                               sif.arr_one_address, sif.arr_reset_counter, sif.arr_address,
                               sif.arr_output_replace_pattern, sif.out_valid, sif.out_data, sif.out_layer}, 0);
            m_busy = 0; m_done = 0; m_err = 0; m_load = 0; m_prev_load = 0; m_in_read = 0;
            m_prev_stall = 0; m_L = 0; m_beats = 0; m_layer = 0; m_gap = 0; m_rd_idx = 0; m_pat = '0;
        end else begin
            hs_in  = sif.in_valid && sif.in_ready;
            hs_out = sif.out_valid && sif.out_ready;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("error", error, m_err);
            chk("in_ready", sif.in_ready, m_load);
            chk("reset_counter", sif.arr_reset_counter, m_load && !m_prev_load);
            if (hs_in) begin
                e_oa = SIZE'(1) << (SIZE - 1 - (m_beats % SIZE));
                chk("one_address", sif.arr_one_address, e_oa);
                chk("z_to_z", sif.arr_z_to_z, sif.in_data);
            end else begin
                chk("idle_beat_zero", {sif.arr_one_address, sif.arr_z_to_z}, 0);
            end
            if (m_busy && !m_in_read) chk("current_layer", sif.arr_current_layer, m_layer);
            chk("replace_pattern", sif.arr_output_replace_pattern, m_in_read ? m_pat : '0);
            if (!m_in_read) begin
                chk("out_valid_off", sif.out_valid, 0);
                chk("address_off", sif.arr_address, 0);
            end else begin
                chk("address_range", sif.arr_address < m_L, 1);
            end
            if (sif.out_valid) chk("out_data", sif.out_data, acc_fn(sif.out_layer));
            if (m_prev_stall) begin
                chk("stall_data_hold", sif.out_data, p_data);
                chk("stall_layer_hold", sif.out_layer, p_layer);
                chk("stall_addr_hold", sif.arr_address, p_addr);
            end
            if (hs_out) chk("out_layer_order", sif.out_layer, m_rd_idx);

            if (hs_in) begin
                if (n_acc < 128) begin
                    oa_log[n_acc]  = int'(sif.arr_one_address);
                    lay_log[n_acc] = int'(sif.arr_current_layer);
                end
                n_acc++;
            end
            if (sif.arr_reset_counter) n_rc++;
            if (error) n_err++;
            if (sif.out_valid && !sif.out_ready) n_stall++;
            if (sif.arr_output_replace_pattern != '0) cap_pat = sif.arr_output_replace_pattern;
            if (hs_out) begin
                if (n_out < 128) out_log[n_out] = int'(sif.out_layer);
                n_out++;
            end

            m_prev_load = m_load;
            m_done = 0;
            m_err  = 0;
            if (start && !m_busy) begin
                if (cfg_layers != 0 && cfg_layers <= MAXL) begin
                    m_busy = 1; m_load = 1; m_L = int'(cfg_layers); m_pat = cfg_pat;
                    m_beats = 0; m_layer = 0; m_gap = 0; m_rd_idx = 0; m_in_read = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (hs_in) begin
                m_beats++;
                if (m_beats % SIZE == 0) begin
                    m_load = 0;
                    m_gap  = DRAIN;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) begin
                    if (m_beats == SIZE*m_L) m_in_read = 1;
                    else begin
                        m_load = 1;
                        m_layer++;
                    end
                end
            end
            if (hs_out && m_in_read) begin
                m_rd_idx++;
                if (m_rd_idx == m_L) begin
                    m_in_read = 0;
                    m_busy    = 0;
                    m_done    = 1;
                end
            end
            m_prev_stall = sif.out_valid && !sif.out_ready;
            p_data  = sif.out_data;
            p_layer = sif.out_layer;
            p_addr  = sif.arr_address;
        end
    end

    int st_cyc = 0;
    int b_acc, b_rc, b_out, b_err, b_stall;

    task automatic snap();
        b_acc = n_acc; b_rc = n_rc; b_out = n_out; b_err = n_err; b_stall = n_stall;
    endtask

    task automatic pulse_start(input logic [31:0] n, input logic [SIZE-1:0] p);
        start = 1'b1; cfg_layers = n; cfg_pat = p; st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - st_cyc;
                break;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL wait_done timeout after %0d cycles, required done", budget);
        end
        @(posedge clk); #1;
    endtask

    int lat;
    bit found;

    initial begin
        sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, error, sif.in_ready, sif.out_valid, sif.arr_reset_counter}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single layer, continuous input
        snap();
        pulse_start(1, '0);
        wait_done(100, lat);
        chk("t1_latency", lat, 12);
        chk("t1_rc_pulses", n_rc - b_rc, 1);
        chk("t1_oa0", oa_log[b_acc], 4);
        chk("t1_oa1", oa_log[b_acc + 1], 2);
        chk("t1_oa2", oa_log[b_acc + 2], 1);

        // three layers, input valid toggling
        snap();
        iv_tog = 1'b1;
        pulse_start(3, '0);
        wait_done(300, lat);
        iv_tog = 1'b0;
        chk("t2_beats", n_acc - b_acc, 9);
        chk("t2_rc_pulses", n_rc - b_rc, 3);
        chk("t2_layer0", lay_log[b_acc], 0);
        chk("t2_layer1", lay_log[b_acc + 3], 1);
        chk("t2_layer2", lay_log[b_acc + 6], 2);

        // readout back-pressure
        snap();
        stall_req = 1'b1;
        pulse_start(3, 3'b011);
        wait_done(300, lat);
        chk("t3_stall_cycles", n_stall - b_stall, 4);
        chk("t3_out_count", n_out - b_out, 3);
        chk("t3_out0", out_log[b_out], 0);
        chk("t3_out1", out_log[b_out + 1], 1);
        chk("t3_out2", out_log[b_out + 2], 2);

        // illegal starts, then a start while busy
        snap();
        pulse_start(0, '0);
        @(posedge clk); #1;
        pulse_start(6, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_pulses", n_err - b_err, 2);
        chk("t4_busy_low", busy, 0);
        pulse_start(2, '0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; cfg_layers = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300, lat);
        chk("t4_out_count", n_out - b_out, 2);
        chk("t4_no_extra_err", n_err - b_err, 2);

        // asynchronous reset in the drain of layer 1
        pulse_start(3, 3'b111);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (busy && sif.arr_current_layer == 32'd1 && !sif.in_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reach_drain", found, 1);
        rst_n = 1'b0;
        #2;
        chk("t5_async_zero", |{busy, sif.in_ready, sif.arr_current_layer, sif.arr_output_replace_pattern,
                              sif.arr_reset_counter, sif.out_valid, sif.arr_one_address}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        snap();
        pulse_start(2, '0);
        wait_done(300, lat);
        chk("t5_out_count", n_out - b_out, 2);

        // replace pattern during readout
        snap();
        pulse_start(3, 3'b101);
        wait_done(300, lat);
        chk("t6_pattern", cap_pat, 3'b101);
        chk("t6_out_count", n_out - b_out, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, required the run to finish");
        $fatal(1);
    end
endmodule
